// File: rtl/aftab_byte_mem_ctrl.sv
// Byte-wide memory for the DARU/DAWU units. It serves one byte per transaction after a fixed
// number of wait states, and flags addresses beyond the internal array with a bus error.
module aftab_byte_mem_ctrl #(
    parameter int size       = 32,
    parameter int waitStates = 2,
    parameter int addrBits   = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            readMem,
    input  logic            writeMem,
    input  logic [size-1:0] addrIn,
    input  logic [7:0]      dataIn,
    output logic [7:0]      memData,
    output logic            memReady,
    output logic            busError,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [size-1:0] addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic            rd_q, rd_d;
    logic [7:0]      mem_data_q, mem_data_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;

    logic [size-1:0] addr_sel;
    logic            rd_sel;
    logic            in_range;

    logic [7:0] mem [0:(2**addrBits)-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            data_q     <= 8'h00;
            rd_q       <= 1'b0;
            mem_data_q <= 8'h00;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_q       <= rd_d;
            mem_data_q <= mem_data_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: begin
                if (readMem || writeMem) begin
                    addr_d  = addrIn;
                    data_d  = dataIn;
                    rd_d    = readMem;
                    cnt_d   = 4'(waitStates);
                    state_d = (waitStates == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered on entry to DONE; with zero wait states that entry is the
    // acceptance edge itself, so the live request is used instead of the latched one.
    always_comb begin
        addr_sel   = (state_q == IDLE) ? addrIn : addr_q;
        rd_sel     = (state_q == IDLE) ? readMem : rd_q;
        in_range   = (addr_sel[size-1:addrBits] == '0);
        ready_d    = (state_d == DONE);
        err_d      = ready_d && !in_range;
        mem_data_d = mem_data_q;
        if (ready_d && rd_sel)
            mem_data_d = in_range ? mem[addr_sel[addrBits-1:0]] : 8'h00;
    end

    // The array is never reset; an asynchronous reset forces IDLE so a pending write is dropped.
    always_ff @(posedge clk) begin
        if (state_q == DONE && !rd_q && addr_q[size-1:addrBits] == '0)
            mem[addr_q[addrBits-1:0]] <= data_q;
    end

    assign memData  = mem_data_q;
    assign memReady = ready_q;
    assign busError = err_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_aftab_byte_mem_ctrl.sv
// Directed bench for aftab_byte_mem_ctrl: a waitStates=2 instance for most scenarios and
// a waitStates=0 instance for the minimum-latency case.
module tb_aftab_byte_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        readMem, writeMem;
    logic [31:0] addrIn;
    logic [7:0]  dataIn;
    logic [7:0]  memData;
    logic        memReady, busError, busy;

    logic        readMem0, writeMem0;
    logic [31:0] addrIn0;
    logic [7:0]  dataIn0;
    logic [7:0]  memData0;
    logic        memReady0, busError0, busy0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aftab_byte_mem_ctrl #(.size(32), .waitStates(2), .addrBits(10)) u_dut (
        .clk(clk), .rst(rst), .readMem(readMem), .writeMem(writeMem), .addrIn(addrIn),
        .dataIn(dataIn), .memData(memData), .memReady(memReady), .busError(busError), .busy(busy)
    );

    aftab_byte_mem_ctrl #(.size(32), .waitStates(0), .addrBits(10)) u_dut0 (
        .clk(clk), .rst(rst), .readMem(readMem0), .writeMem(writeMem0), .addrIn(addrIn0),
        .dataIn(dataIn0), .memData(memData0), .memReady(memReady0), .busError(busError0),
        .busy(busy0)
    );

    // Single transaction on the waitStates=2 instance; lat counts cycles from acceptance to memReady.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] a, input logic [7:0] d,
                         output int lat, output logic [7:0] q, output logic err);
        @(posedge clk); #1;
        readMem = rd; writeMem = wr; addrIn = a; dataIn = d;
        lat = -1; q = 8'h00; err = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (memReady) begin
                lat = i; q = memData; err = busError;
                break;
            end
        end
        @(posedge clk); #1;
        readMem = 1'b0; writeMem = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (memReady) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        readMem = 0; writeMem = 0; addrIn = 0; dataIn = 0;
        readMem0 = 0; writeMem0 = 0; addrIn0 = 0; dataIn0 = 0;
        #12;
        checks++; if (memReady !== 1'b0) begin failures++; $display("FAIL reset_memReady: got %b want 0", memReady); end
        checks++; if (busError !== 1'b0) begin failures++; $display("FAIL reset_busError: got %b want 0", busError); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (memData !== 8'h00) begin failures++; $display("FAIL reset_memData: got %h want 00", memData); end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({memReady, busError, busy, memData} !== 11'd0) begin
                failures++;
                $display("FAIL idle_outputs cycle %0d: got rdy=%b err=%b busy=%b data=%h want all 0",
                         i, memReady, busError, busy, memData);
            end
        end
    endtask

    task automatic test_write_read();
        int lat; logic [7:0] q; logic err;
        do_op(1'b0, 1'b1, 32'h10, 8'hA5, lat, q, err);
        checks++; if (lat !== 3) begin failures++; $display("FAIL write_latency: got %0d want 3", lat); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL write_busError: got %b want 0", err); end
        checks++; if (memData !== 8'h00) begin failures++; $display("FAIL write_keeps_memData: got %h want 00", memData); end
        do_op(1'b1, 1'b0, 32'h10, 8'h00, lat, q, err);
        checks++; if (lat !== 3) begin failures++; $display("FAIL read_latency: got %0d want 3", lat); end
        checks++; if (q !== 8'hA5) begin failures++; $display("FAIL read_data_10: got %h want a5", q); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL read_busError: got %b want 0", err); end
    endtask

    task automatic test_daru_word();
        int lat, n, cnt, last; logic [7:0] q; logic err; logic [31:0] word;
        do_op(1'b0, 1'b1, 32'h20, 8'h11, lat, q, err);
        do_op(1'b0, 1'b1, 32'h21, 8'h22, lat, q, err);
        do_op(1'b0, 1'b1, 32'h22, 8'h33, lat, q, err);
        do_op(1'b0, 1'b1, 32'h23, 8'h44, lat, q, err);
        @(posedge clk); #1;
        readMem = 1'b1; addrIn = 32'h20;
        n = 0; cnt = 0; last = 0; word = 32'h0;
        while (n < 4 && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (memReady) begin
                word[8*n +: 8] = memData;
                if (n > 0) begin
                    checks++;
                    if (cnt - last !== 4) begin failures++; $display("FAIL daru_spacing byte %0d: got %0d want 4", n, cnt - last); end
                end
                last = cnt;
                n++;
                addrIn = addrIn + 32'd1;
                if (n == 4) readMem = 1'b0;
            end
        end
        readMem = 1'b0;
        checks++; if (n !== 4) begin failures++; $display("FAIL daru_complete: got %0d bytes want 4", n); end
        checks++; if (word !== 32'h44332211) begin failures++; $display("FAIL daru_word: got %h want 44332211", word); end
    endtask

    task automatic test_simultaneous();
        int lat; logic [7:0] q; logic err;
        do_op(1'b0, 1'b1, 32'h30, 8'h5A, lat, q, err);
        @(posedge clk); #1;
        readMem = 1'b1; writeMem = 1'b1; addrIn = 32'h30; dataIn = 8'hFF;
        wait_ready(lat);
        checks++; if (lat < 0) begin failures++; $display("FAIL simul_read_ready: got timeout want memReady"); end
        checks++; if (memData !== 8'h5A) begin failures++; $display("FAIL simul_read_data: got %h want 5a", memData); end
        checks++; if (busError !== 1'b0) begin failures++; $display("FAIL simul_busError: got %b want 0", busError); end
        readMem = 1'b0;
        wait_ready(lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL simul_write_gap: got %0d want 4", lat); end
        writeMem = 1'b0;
        do_op(1'b1, 1'b0, 32'h30, 8'h00, lat, q, err);
        checks++; if (q !== 8'hFF) begin failures++; $display("FAIL simul_write_data: got %h want ff", q); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [7:0] q; logic err;
        do_op(1'b0, 1'b1, 32'h000, 8'h3C, lat, q, err);
        do_op(1'b1, 1'b0, 32'h400, 8'h00, lat, q, err);
        checks++; if (lat !== 3) begin failures++; $display("FAIL oor_read_latency: got %0d want 3", lat); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL oor_read_busError: got %b want 1", err); end
        checks++; if (q !== 8'h00) begin failures++; $display("FAIL oor_read_data: got %h want 00", q); end
        @(negedge clk);
        checks++; if (busError !== 1'b0) begin failures++; $display("FAIL oor_busError_one_cycle: got %b want 0", busError); end
        do_op(1'b0, 1'b1, 32'h400, 8'hEE, lat, q, err);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL oor_write_busError: got %b want 1", err); end
        do_op(1'b1, 1'b0, 32'h000, 8'h00, lat, q, err);
        checks++; if (q !== 8'h3C) begin failures++; $display("FAIL oor_no_alias: got %h want 3c", q); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL inrange_busError: got %b want 0", err); end
    endtask

    task automatic test_reset_mid_op();
        int lat; logic [7:0] q; logic err; logic seen;
        do_op(1'b0, 1'b1, 32'h40, 8'h11, lat, q, err);
        @(posedge clk); #1;
        writeMem = 1'b1; addrIn = 32'h40; dataIn = 8'h77;
        @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midop_busy_wait: got %b want 1", busy); end
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midop_busy_reset: got %b want 0", busy); end
        checks++; if (memData !== 8'h00) begin failures++; $display("FAIL midop_memData_reset: got %h want 00", memData); end
        writeMem = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (memReady) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midop_no_ready: got %b want 0", seen); end
        @(posedge clk); #1;
        rst = 1'b1;
        do_op(1'b1, 1'b0, 32'h40, 8'h00, lat, q, err);
        checks++; if (q !== 8'h11) begin failures++; $display("FAIL midop_prior_value: got %h want 11", q); end
    endtask

    task automatic test_zero_wait();
        int lat;
        @(posedge clk); #1;
        writeMem0 = 1'b1; addrIn0 = 32'h5; dataIn0 = 8'h9C;
        @(posedge clk);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (memReady0) begin lat = i; break; end
        end
        checks++; if (lat !== 1) begin failures++; $display("FAIL ws0_write_latency: got %0d want 1", lat); end
        @(posedge clk); #1;
        writeMem0 = 1'b0; readMem0 = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (memReady0) begin lat = i; break; end
        end
        checks++; if (lat !== 1) begin failures++; $display("FAIL ws0_read_latency: got %0d want 1", lat); end
        checks++; if (memData0 !== 8'h9C) begin failures++; $display("FAIL ws0_read_data: got %h want 9c", memData0); end
        @(posedge clk); #1;
        readMem0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_daru_word();
        test_simultaneous();
        test_out_of_range();
        test_reset_mid_op();
        test_zero_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aftab_byte_mem_ctrl.md
Name: aftab_byte_mem_ctrl

Overview:
Byte-wide memory controller that directly feeds aftab_MEM_DARU with memData/memReady and accepts byte writes from the data write unit (DAWU). It serves one byte per transaction, inserts a configurable number of wait states, and stores bytes in an internal array. It flags out-of-range accesses with a one-cycle bus error.

Parameters:
size, 32, address width of addrIn
waitStates, 2, wait cycles inserted before completion (0..15)
addrBits, 10, internal array depth is 2**addrBits bytes

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
readMem  input  1  byte read request from DARU, held until memReady
writeMem  input  1  byte write request from DAWU, held until memReady
addrIn  input  size  byte address, valid while a request is high
dataIn  input  8  write byte, valid while writeMem is high
memData  output  8  read byte to DARU
memReady  output  1  one-cycle completion strobe
busError  output  1  one-cycle strobe with memReady when the address is out of range
busy  output  1  high while a transaction is in flight (WAIT or DONE)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, memReady=0, busError=0, busy=0, memData=8'h00, wait counter 0. Array contents are not cleared.
- FSM states: IDLE, WAIT, DONE.
- IDLE: at a clock edge with readMem or writeMem high:
  - latch addrIn, dataIn and the operation (read priority: if both are high, the read is taken and writeMem is ignored; the writer must keep holding).
  - load the counter with waitStates.
  - next state is WAIT if waitStates>0, else DONE.
- WAIT: the counter decrements each cycle. When the counter reaches 1 and is decremented, the next state is DONE. Request lines are ignored in WAIT; dropping a request does not abort the transaction.
- DONE (exactly one cycle): memReady=1.
  - Read: memData is registered from array[latched addr] on entry to DONE and holds that value until the next read completes.
  - Write: array[latched addr] <= latched data at the DONE->IDLE edge.
  - Next state is always IDLE. Requests are not sampled in DONE, so the earliest next acceptance is the first IDLE cycle.
- Latency: a request sampled at edge N produces memReady high during cycle N+waitStates+1, i.e. waitStates+1 cycles after acceptance. Back-to-back throughput is one byte per waitStates+2 cycles.
- Range check: the address is in range when addr[size-1:addrBits]==0.
  - Out of range: busError=1 together with memReady in DONE.
  - Read: memData=8'h00.
  - Write: the array is not modified.
- Only addr[addrBits-1:0] indexes the array; there is no wrap-around aliasing, because upper bits produce busError.
- busy=1 in WAIT and DONE, 0 in IDLE.
- memReady and busError are registered outputs (glitch-free). They are never high outside DONE.
- Reset during WAIT/DONE: the transaction is aborted immediately, no array write occurs, and all outputs return to reset values.
- Compatible with the DARU sequencing. DARU holds readMem, increments its address on memReady, and re-requests. The controller accepts the new address in the following IDLE cycle, so a 4-byte word read takes 4*(waitStates+2) cycles.

Test Plan:
- Reset check: rst=0 with waitStates=2 -> memReady=0, busError=0, busy=0, memData=00. Release rst, hold idle 5 cycles -> outputs unchanged.
- Write then read: write addr 0x10 data 0xA5. memReady is expected in the 3rd cycle after acceptance. Then read 0x10 -> memData=0xA5 with memReady, and busError=0.
- DARU word read: preload 0x20..0x23 = 11,22,33,44 and drive with aftab_MEM_DARU, nBytes=2'b11, addr 0x20 -> dataOut=0x44332211. completeDARU is asserted and four memReady pulses are spaced 4 cycles apart.
- Simultaneous request: readMem=writeMem=1 at addr 0x30 (old 0x5A), dataIn 0xFF -> read completes with memData=0x5A. The write then completes on the next acceptance and array[0x30]=0xFF.
- Out of range: read addr 0x400 with addrBits=10 -> memReady=1, busError=1, memData=00. A write to 0x400 leaves array[0x000] unchanged.
- Reset mid-operation: write 0x40 data 0x77, assert rst in WAIT -> no memReady. After release, reading 0x40 returns the prior value. With waitStates=0, read latency is 1 cycle.
